// File: rtl/key_matrix_pkg.sv
// Shared definitions for the key matrix scanner: FSM encoding, event field
// layout and a width helper used to size every counter in the design.
package key_matrix_pkg;

   // Scanner FSM: DRIVE settles a column, EVAL walks its rows.
   typedef enum logic {
      ST_DRIVE = 1'b0,
      ST_EVAL  = 1'b1
   } scan_state_t;

   // Bits needed to hold values 0 .. n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Key index width for a ROWS x COLS matrix.
   function automatic int key_width(input int rows, input int cols);
      return cnt_width(rows * cols);
   endfunction

   // Event word layout when release events are carried: {key, press}.
   localparam int EVT_PRESS_LSB = 0;
   localparam int EVT_KEY_LSB   = 1;

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue. A push is only taken when the queue
// is not full at the start of the cycle; a simultaneous pop does not make
// room for it. The head word reads as zero while the queue is empty.
module key_event_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_full,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_push_ok  = i_push & ~o_full;
   assign w_pop_ok   = i_pop & ~o_empty;
   assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

   // Pointer update; reset discards everything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: drives one column low at a time, samples the rows after
// a settle time, debounces each key with a per-key scan counter and queues
// press (and optionally release) events.
// Build option: define KEY_MATRIX_RELEASE_EVT_EN to also queue release events.
//
// Event handshake: evt_valid is high whenever the queue holds an event and
// evt_key/evt_press show the oldest one; the event is consumed on any clock
// edge where evt_valid and evt_ready are both high. evt_valid never drops
// without that transfer except on reset.
module key_matrix_scanner
   import key_matrix_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYCLES  = 100,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          scan_en,
   input  logic [ROWS-1:0]               row_in,
   output logic [COLS-1:0]               col_n,
   output logic [ROWS*COLS-1:0]          key_state,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [$clog2(ROWS*COLS)-1:0]  evt_key,
   output logic                          evt_press,
   output logic                          o_dbg_state
);

   localparam int N     = ROWS * COLS;
   localparam int KEY_W = key_width(ROWS, COLS);
   localparam int COL_W = cnt_width(COLS);
   localparam int ROW_W = cnt_width(ROWS);
   localparam int SET_W = cnt_width(SETTLE_CYCLES);
   localparam int CNT_W = cnt_width(DEBOUNCE_SCANS);
`ifdef KEY_MATRIX_RELEASE_EVT_EN
   localparam int EVT_W = KEY_W + 1;
`else
   localparam int EVT_W = KEY_W;
`endif

   scan_state_t      r_state, w_state_nxt;
   logic [SET_W-1:0] r_settle, w_settle_nxt;
   logic [COL_W-1:0] r_col, w_col_nxt;
   logic [ROW_W-1:0] r_row, w_row_nxt;
   logic [ROWS-1:0]  r_sample, w_sample_nxt;
   logic [N-1:0]     r_key_state, w_key_state_nxt;
   logic [CNT_W-1:0] r_cnt [N];
   logic [CNT_W-1:0] w_cnt_nxt [N];
   logic [COLS-1:0]  r_col_n, w_col_n_nxt;

   logic [KEY_W-1:0] w_key;
   logic             w_smp;
   logic             w_need_evt;
   logic             w_push;
   logic [EVT_W-1:0] w_push_data;
   logic [EVT_W-1:0] w_head;
   logic             w_full;
   logic             w_empty;

   assign w_key = KEY_W'(r_col) * KEY_W'(ROWS) + KEY_W'(r_row);
   assign w_smp = r_sample[r_row];

`ifdef KEY_MATRIX_RELEASE_EVT_EN
   assign w_need_evt  = 1'b1;
   assign w_push_data = {w_key, w_smp};
   assign evt_key     = w_head[EVT_W-1:EVT_KEY_LSB];
   assign evt_press   = w_head[EVT_PRESS_LSB];
`else
   assign w_need_evt  = w_smp;
   assign w_push_data = w_key;
   assign evt_key     = w_head;
   assign evt_press   = 1'b1;
`endif

   assign col_n       = r_col_n;
   assign key_state   = r_key_state;
   assign evt_valid   = ~w_empty;
   assign o_dbg_state = (r_state == ST_EVAL);

   // Next-state logic: column settle/sample, per-row debounce and event push.
   always_comb begin
      w_state_nxt     = r_state;
      w_settle_nxt    = r_settle;
      w_col_nxt       = r_col;
      w_row_nxt       = r_row;
      w_sample_nxt    = r_sample;
      w_key_state_nxt = r_key_state;
      w_cnt_nxt       = r_cnt;
      w_push          = 1'b0;
      case (r_state)
         ST_DRIVE: begin
            if (!scan_en) begin
               w_settle_nxt = '0;
            end else if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
               w_sample_nxt = ~row_in;
               w_settle_nxt = '0;
               w_row_nxt    = '0;
               w_state_nxt  = ST_EVAL;
            end else begin
               w_settle_nxt = r_settle + SET_W'(1);
            end
         end
         ST_EVAL: begin
            // A change that needs a queue slot while the queue is full
            // freezes the FSM on this row; nothing else moves.
            if (!(w_smp != r_key_state[w_key] &&
                  r_cnt[w_key] >= CNT_W'(DEBOUNCE_SCANS - 1) &&
                  w_need_evt && w_full)) begin
               if (w_smp == r_key_state[w_key]) begin
                  w_cnt_nxt[w_key] = '0;
               end else if (r_cnt[w_key] < CNT_W'(DEBOUNCE_SCANS - 1)) begin
                  w_cnt_nxt[w_key] = r_cnt[w_key] + CNT_W'(1);
               end else begin
                  w_key_state_nxt[w_key] = w_smp;
                  w_cnt_nxt[w_key]       = '0;
                  w_push                 = w_need_evt;
               end
               if (r_row == ROW_W'(ROWS - 1)) begin
                  w_row_nxt   = '0;
                  w_col_nxt   = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
                  w_state_nxt = ST_DRIVE;
               end else begin
                  w_row_nxt = r_row + ROW_W'(1);
               end
            end
         end
         default: w_state_nxt = ST_DRIVE;
      endcase
      // Pins are registered so reset forces them high immediately.
      if (w_state_nxt == ST_EVAL || scan_en) begin
         w_col_n_nxt = ~(COLS'(1) << w_col_nxt);
      end else begin
         w_col_n_nxt = '1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_DRIVE;
         r_settle    <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_sample    <= '0;
         r_key_state <= '0;
         r_cnt       <= '{default: '0};
         r_col_n     <= '1;
      end else begin
         r_state     <= w_state_nxt;
         r_settle    <= w_settle_nxt;
         r_col       <= w_col_nxt;
         r_row       <= w_row_nxt;
         r_sample    <= w_sample_nxt;
         r_key_state <= w_key_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_col_n     <= w_col_n_nxt;
      end
   end

   key_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .o_full      (w_full),
      .i_pop       (evt_valid & evt_ready),
      .o_pop_data  (w_head),
      .o_empty     (w_empty)
   );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner on a 2x2 matrix. A small matrix model
// turns the set of held keys into row levels from the driven column.
module tb_key_matrix_scanner;

   logic       clk;
   logic       rst_n;
   logic       scan_en;
   logic [1:0] row_in;
   logic [1:0] col_n;
   logic [3:0] key_state;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_key;
   logic       evt_press;
   logic       dbg_state;

   logic [3:0] keys;
   int         n_assert;
   int         n_fail;

`ifdef KEY_MATRIX_RELEASE_EVT_EN
   localparam logic RESET_PRESS = 1'b0;
`else
   localparam logic RESET_PRESS = 1'b1;
`endif

   key_matrix_scanner #(
      .ROWS           (2),
      .COLS           (2),
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_SCANS (3),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_en     (scan_en),
      .row_in      (row_in),
      .col_n       (col_n),
      .key_state   (key_state),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_key     (evt_key),
      .evt_press   (evt_press),
      .o_dbg_state (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: a row reads low when a held key sits on a driven column.
   always_comb begin
      row_in = 2'b11;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (keys[c*2+r] && !col_n[c]) row_in[r] = 1'b0;
         end
      end
   end

   function automatic logic [1:0] col_mask(input int c);
      logic [1:0] m;
      m = 2'b11;
      m[c] = 1'b0;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until column c is in EVAL.
   task automatic wait_eval(input int c);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (dbg_state === 1'b1 && col_n === col_mask(c)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("wait_eval", 32'(ok), 32'd1);
   endtask

   // Complete one scan of column c; returns on the first DRIVE cycle after it.
   task automatic scan_col(input int c);
      bit ok;
      wait_eval(c);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (dbg_state === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("wait_drive", 32'(ok), 32'd1);
   endtask

   // Wait for an event, check it and accept it with a one-cycle ready pulse.
   task automatic pop_expect(input logic [1:0] k, input logic p);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (evt_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("pop_valid", 32'(ok), 32'd1);
      chk("pop_key", 32'(evt_key), 32'(k));
      chk("pop_press", 32'(evt_press), 32'(p));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   // Count consecutive cycles col_n holds value v; report the value after.
   task automatic run_len(input logic [1:0] v, output int n, output logic [1:0] nxt);
      n = 0;
      while (col_n === v && n < 50) begin
         n++;
         @(negedge clk);
      end
      nxt = col_n;
   endtask

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [1:0] nxt;
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      scan_en   = 1'b0;
      evt_ready = 1'b0;
      keys      = 4'b0000;

      // Reset values.
      repeat (2) @(negedge clk);
      chk("rst_col_n", 32'(col_n), 32'h3);
      chk("rst_key_state", 32'(key_state), 32'h0);
      chk("rst_evt_valid", 32'(evt_valid), 32'h0);
      chk("rst_evt_key", 32'(evt_key), 32'h0);
      chk("rst_evt_press", 32'(evt_press), 32'(RESET_PRESS));
      chk("rst_state", 32'(dbg_state), 32'h0);

      // Scanning disabled: pins idle, FSM parked in DRIVE.
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("dis_col_n", 32'(col_n), 32'h3);
      chk("dis_state", 32'(dbg_state), 32'h0);

      // Idle scan: each column held low for 6 clocks, alternating.
      scan_en = 1'b1;
      wait_eval(1);
      scan_col(1);
      run_len(2'b10, n, nxt);
      chk("idle_col0_len", 32'(n), 32'd6);
      chk("idle_col0_next", 32'(nxt), 32'h1);
      run_len(2'b01, n, nxt);
      chk("idle_col1_len", 32'(n), 32'd6);
      chk("idle_col1_next", 32'(nxt), 32'h2);
      chk("idle_key_state", 32'(key_state), 32'h0);
      chk("idle_evt_valid", 32'(evt_valid), 32'h0);

      // Press key 2 (col 1, row 0): accepted on the third col-1 scan.
      scan_col(1);
      keys = 4'b0100;
      scan_col(1);
      scan_col(1);
      chk("p2_pre_state", 32'(key_state), 32'h0);
      chk("p2_pre_valid", 32'(evt_valid), 32'h0);
      scan_col(1);
      chk("p2_state", 32'(key_state), 32'h4);
      pop_expect(2'd2, 1'b1);
      chk("p2_drained", 32'(evt_valid), 32'h0);

      // Release key 2.
      scan_col(1);
      keys = 4'b0000;
      scan_col(1);
      scan_col(1);
      chk("r2_pre_state", 32'(key_state), 32'h4);
      scan_col(1);
      chk("r2_state", 32'(key_state), 32'h0);
`ifdef KEY_MATRIX_RELEASE_EVT_EN
      pop_expect(2'd2, 1'b0);
`endif
      chk("r2_drained", 32'(evt_valid), 32'h0);

      // Bounce: 2 scans pressed, 1 released, twice -> nothing accepted.
      for (int rep = 0; rep < 2; rep++) begin
         keys = 4'b0100;
         scan_col(1);
         scan_col(1);
         keys = 4'b0000;
         scan_col(1);
         chk("bounce_state", 32'(key_state), 32'h0);
         chk("bounce_valid", 32'(evt_valid), 32'h0);
      end

      // All keys pressed with the consumer stalled: four events fill the queue.
      keys = 4'b1111;
      for (int s = 0; s < 3; s++) begin
         scan_col(0);
         scan_col(1);
      end
      chk("all_state", 32'(key_state), 32'hF);
      chk("all_valid", 32'(evt_valid), 32'h1);
      chk("all_head_key", 32'(evt_key), 32'h0);
      keys = 4'b0000;
`ifdef KEY_MATRIX_RELEASE_EVT_EN
      // Release of key 0 needs a slot: EVAL freezes on col 0 with pins held.
      scan_col(0);
      scan_col(1);
      scan_col(0);
      scan_col(1);
      wait_eval(0);
      repeat (8) @(negedge clk);
      chk("stall_state", 32'(dbg_state), 32'h1);
      chk("stall_col_n", 32'(col_n), 32'h2);
      chk("stall_key_state", 32'(key_state), 32'hF);
      for (int k = 0; k < 4; k++) pop_expect(2'(k), 1'b1);
      for (int k = 0; k < 4; k++) pop_expect(2'(k), 1'b0);
`else
      for (int s = 0; s < 3; s++) begin
         scan_col(0);
         scan_col(1);
      end
      for (int k = 0; k < 4; k++) pop_expect(2'(k), 1'b1);
`endif
      chk("all_rel_state", 32'(key_state), 32'h0);
      chk("all_rel_valid", 32'(evt_valid), 32'h0);

      // Key 1 press then release.
      scan_col(1);
      keys = 4'b0010;
      for (int s = 0; s < 3; s++) scan_col(0);
      chk("k1_state", 32'(key_state), 32'h2);
      pop_expect(2'd1, 1'b1);
      scan_col(1);
      keys = 4'b0000;
      for (int s = 0; s < 3; s++) scan_col(0);
      chk("k1_rel_state", 32'(key_state), 32'h0);
`ifdef KEY_MATRIX_RELEASE_EVT_EN
      pop_expect(2'd1, 1'b0);
`endif
      chk("k1_rel_valid", 32'(evt_valid), 32'h0);

      // Reset during EVAL with two events queued.
      scan_col(1);
      keys = 4'b0011;
      for (int s = 0; s < 3; s++) scan_col(0);
      chk("pre_rst_valid", 32'(evt_valid), 32'h1);
      chk("pre_rst_state", 32'(key_state), 32'h3);
      wait_eval(1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(evt_valid), 32'h0);
      chk("mid_rst_key_state", 32'(key_state), 32'h0);
      chk("mid_rst_col_n", 32'(col_n), 32'h3);
      chk("mid_rst_fsm", 32'(dbg_state), 32'h0);
      @(negedge clk);
      keys  = 4'b0000;
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
